eth_tx_arbiter: RTL and testbench
=================================

# eth_tx_arbiter

Frame-atomic AXI-Stream arbiter that shares the single Ethernet MAC transmit port between two frame sources. Source 0 is the RVVI trace packetizer; source 1 is the control/reply frame generator (rate acknowledgements, status). It sits between those producers and the MAC TX FIFO. It guarantees whole-frame interleaving, bounded starvation of the control source, and a programmable idle gap between frames.

## Interface
Parameters:
- DATA_WIDTH, 32, stream data width in bits.
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
- MAX_GRANTS, 4, maximum consecutive source-0 frames granted while source 1 waits; must be ≥1.

Ports:
- m_axi_aclk  in  1  sole clock.
- m_axi_aresetn  in  1  reset, asynchronous assert, active-low.
- S0Tdata / S0Tkeep  in  DATA_WIDTH / KEEP_WIDTH  source 0 beat.
- S0Tvalid, S0Tlast  in  1  source 0 valid, end of frame.
- S0Tready  out  1  source 0 ready.
- S1Tdata / S1Tkeep / S1Tvalid / S1Tlast  in  same widths  source 1 beat.
- S1Tready  out  1  source 1 ready.
- MTdata / MTkeep / MTvalid / MTlast  out  same widths  to MAC.
- MTready  in  1  MAC ready.
- GapCycles  in  8  idle cycles inserted after each frame; sampled on the last beat.
- Grant  out  2  one-hot current owner; 2'b00 when none.
- Busy  out  1  high in XFER or GAP.

## Operation
- State machine: IDLE, XFER, GAP.
- IDLE:
  - No valid source: stay in IDLE.
  - Exactly one source valid: grant it.
  - Both valid: grant source 0, unless RunCnt == MAX_GRANTS; then grant source 1.
  - On a grant: register Grant and go to XFER.
- RunCnt, 0..MAX_GRANTS:
  - Increments when source 0 is granted while S1Tvalid is high.
  - Clears when source 1 is granted.
  - Clears when source 0 is granted with S1Tvalid low.
  - Saturates at MAX_GRANTS.
- XFER:
  - Datapath is combinational: the selected source's data/keep/valid/last drive MT*, and the selected SxTready = MTready.
  - Non-selected ready is 0.
- A beat transfers when MTvalid & MTready.
  - Transferred beat with MTlast: latch GapCycles. Next state is GAP if the latched value ≠ 0, else IDLE. Grant clears to 0.
- GAP: down-counter loaded with GapCycles. Exits to IDLE on the cycle the count reaches 1, so exactly GapCycles cycles are spent in GAP.
- IDLE and GAP outputs: MTvalid = 0, both SxTready = 0, MTdata/MTkeep/MTlast = 0.
- A granted source that drops Tvalid mid-frame stalls the port. Grant is held; no preemption; no timeout.
- Once granted, a frame always completes before any other source is considered.
- Reset, including mid-frame:
  - State IDLE, RunCnt 0, gap counter 0, Grant 0, Busy 0.
  - MTvalid 0, S0Tready 0, S1Tready 0.
  - The truncated frame is left for the MAC to discard as a bad frame.

## Timing
- Arbitration latency: 1 cycle. The decision is registered in IDLE; the first beat can transfer in the next cycle.
- Frame-to-frame minimum: last beat at cycle t, next grant decision at t+1+GapCycles, next first beat at t+2+GapCycles.
- Throughput inside a frame: 1 beat/cycle; no bubbles inserted.
- Output valid/data path is combinational from inputs (ready→ready, valid→valid). No registers in the data path.
- Single-beat frame (valid & last on the first beat) completes in one XFER cycle.
- GapCycles changes outside the last-beat cycle have no effect on the current frame.

## Configuration
- ETH_TX_ARB_STATS_EN defined:
  - Adds outputs Frames0 [31:0] and Frames1 [31:0], counting completed frames per source.
  - Each counter increments on a transferred last beat of its source and wraps modulo 2^32.
  - Both reset to 0.
- Undefined: those ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package cvw gains:
  - Enum typedef ethtxarbstate_t {IDLE, XFER, GAP}.
  - Localparam ARB_SRC_TRACE = 0 and ARB_SRC_CTRL = 1, indexing the Grant bits.
- One sub-module: eth_tx_gapcounter, an 8-bit loadable down-counter with a done flag, used for GAP.
- The arbiter FSM, RunCnt and mux stay in eth_tx_arbiter.

## Test plan
- Only S0 has a 3-beat frame, MTready = 1, GapCycles = 0 → Grant = 01 one cycle after S0Tvalid. MT* mirrors 3 beats on consecutive cycles. Grant = 00 after the last beat.
- S0 and S1 both continuously valid, 2-beat frames, MAX_GRANTS = 4, GapCycles = 0 → grant order S0, S0, S0, S0, S1, S0, S0, S0, S0, S1. Every frame is contiguous on MT.
- GapCycles = 5, back-to-back S0 frames → exactly 5 cycles of Busy = 1 and MTvalid = 0 between the last beat and the next arbitration cycle.
- MTready toggles 1,0,1,0 during a 4-beat S1 frame while S0Tvalid = 1 → S0Tready stays 0 throughout. Beats are not duplicated or dropped. S0 is granted only after the S1 last beat.
- Assert m_axi_aresetn low on the 2nd beat of a 4-beat frame → MTvalid, S0Tready, S1Tready, Grant and Busy go to 0 immediately (asynchronously). After release, a new frame arbitrates normally with RunCnt = 0.
- With ETH_TX_ARB_STATS_EN: 7 S0 frames and 3 S1 frames → Frames0 = 7, Frames1 = 3. Preloading a counter to 32'hFFFFFFFF and sending 1 frame yields 0.

Source files
------------

// File: rtl/eth_tx_arbiter_pkg.sv
// Shared cvw package slice: arbiter state encoding and Grant bit indices.
// Used by eth_tx_arbiter (optional ETH_TX_ARB_STATS_EN frame counters).
package cvw;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        GAP
    } ethtxarbstate_t;

    localparam int ARB_SRC_TRACE = 0;
    localparam int ARB_SRC_CTRL  = 1;

endpackage

// File: rtl/eth_tx_gapcounter.sv
// 8-bit loadable down-counter timing the inter-frame idle gap.
// done is high on the final gap cycle (count == 1).
module eth_tx_gapcounter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] value,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= value;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = (count == 8'd1);

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic two-source AXI-Stream arbiter in front of the MAC TX FIFO.
// Define ETH_TX_ARB_STATS_EN to add per-source completed-frame counters.
module eth_tx_arbiter
    import cvw::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MAX_GRANTS = 4
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic [DATA_WIDTH-1:0] S0Tdata,
    input  logic [KEEP_WIDTH-1:0] S0Tkeep,
    input  logic                  S0Tvalid,
    input  logic                  S0Tlast,
    output logic                  S0Tready,
    input  logic [DATA_WIDTH-1:0] S1Tdata,
    input  logic [KEEP_WIDTH-1:0] S1Tkeep,
    input  logic                  S1Tvalid,
    input  logic                  S1Tlast,
    output logic                  S1Tready,
    output logic [DATA_WIDTH-1:0] MTdata,
    output logic [KEEP_WIDTH-1:0] MTkeep,
    output logic                  MTvalid,
    output logic                  MTlast,
    input  logic                  MTready,
    input  logic [7:0]            GapCycles,
    output logic [1:0]            Grant,
`ifdef ETH_TX_ARB_STATS_EN
    output logic [31:0]           Frames0,
    output logic [31:0]           Frames1,
`endif
    output logic                  Busy
);

    localparam int RW = $clog2(MAX_GRANTS + 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_GRANTS);

    ethtxarbstate_t state;
    logic [RW-1:0]  run_cnt;
    logic           any_valid;
    logic           pick_ctrl;
    logic           beat;
    logic           frame_end;
    logic           gap_done;

    assign any_valid = S0Tvalid | S1Tvalid;
    // Control source wins only when alone or when trace has used its run.
    assign pick_ctrl = S1Tvalid & (~S0Tvalid | (run_cnt == RUN_MAX));
    assign beat      = MTvalid & MTready;
    assign frame_end = (state == XFER) & beat & MTlast;
    assign Busy      = (state != IDLE);

    eth_tx_gapcounter u_gap (
        .clk   (m_axi_aclk),
        .rst_n (m_axi_aresetn),
        .load  (frame_end),
        .value (GapCycles),
        .done  (gap_done)
    );

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state   <= IDLE;
            Grant   <= 2'b00;
            run_cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_valid) begin
                        state <= XFER;
                        Grant <= pick_ctrl ? 2'b10 : 2'b01;
                        if (pick_ctrl || !S1Tvalid) begin
                            run_cnt <= '0;
                        end else if (run_cnt != RUN_MAX) begin
                            run_cnt <= run_cnt + RW'(1);
                        end
                    end
                end
                XFER: begin
                    if (frame_end) begin
                        Grant <= 2'b00;
                        state <= (GapCycles != 8'd0) ? GAP : IDLE;
                    end
                end
                GAP: begin
                    if (gap_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    Grant <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        MTdata   = '0;
        MTkeep   = '0;
        MTvalid  = 1'b0;
        MTlast   = 1'b0;
        S0Tready = 1'b0;
        S1Tready = 1'b0;
        unique case (1'b1)
            Grant[ARB_SRC_TRACE]: begin
                MTdata   = S0Tdata;
                MTkeep   = S0Tkeep;
                MTvalid  = S0Tvalid;
                MTlast   = S0Tlast;
                S0Tready = MTready;
            end
            Grant[ARB_SRC_CTRL]: begin
                MTdata   = S1Tdata;
                MTkeep   = S1Tkeep;
                MTvalid  = S1Tvalid;
                MTlast   = S1Tlast;
                S1Tready = MTready;
            end
            default: begin
            end
        endcase
    end

`ifdef ETH_TX_ARB_STATS_EN
    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            Frames0 <= 32'd0;
            Frames1 <= 32'd0;
        end else if (frame_end) begin
            if (Grant[ARB_SRC_TRACE]) Frames0 <= Frames0 + 32'd1;
            if (Grant[ARB_SRC_CTRL])  Frames1 <= Frames1 + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: arbitration order, gaps, stalls, reset.
// Frame counters are checked when ETH_TX_ARB_STATS_EN is defined.
module tb_eth_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] S0Tdata, S1Tdata, MTdata;
    logic [3:0]  S0Tkeep, S1Tkeep, MTkeep;
    logic        S0Tvalid, S0Tlast, S0Tready;
    logic        S1Tvalid, S1Tlast, S1Tready;
    logic        MTvalid, MTlast, MTready;
    logic [7:0]  GapCycles;
    logic [1:0]  Grant;
    logic        Busy;
`ifdef ETH_TX_ARB_STATS_EN
    logic [31:0] Frames0, Frames1;
`endif

    int checks = 0;
    int failures = 0;
    int ef0 = 0;
    int ef1 = 0;
    int fg, lf;

    eth_tx_arbiter dut (
        .m_axi_aclk    (clk),
        .m_axi_aresetn (rst_n),
        .S0Tdata       (S0Tdata),
        .S0Tkeep       (S0Tkeep),
        .S0Tvalid      (S0Tvalid),
        .S0Tlast       (S0Tlast),
        .S0Tready      (S0Tready),
        .S1Tdata       (S1Tdata),
        .S1Tkeep       (S1Tkeep),
        .S1Tvalid      (S1Tvalid),
        .S1Tlast       (S1Tlast),
        .S1Tready      (S1Tready),
        .MTdata        (MTdata),
        .MTkeep        (MTkeep),
        .MTvalid       (MTvalid),
        .MTlast        (MTlast),
        .MTready       (MTready),
        .GapCycles     (GapCycles),
        .Grant         (Grant),
`ifdef ETH_TX_ARB_STATS_EN
        .Frames0       (Frames0),
        .Frames1       (Frames1),
`endif
        .Busy          (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sources present frames; data = {src, frame, beat}. Checks the port.
    task automatic run(input int n0, input int n1, input int len0,
                       input int len1, input int d0, input logic tog,
                       input logic [15:0] order,
                       output int first_grant, output int last_fire);
        int f0 = 0, f1 = 0, b0 = 0, b1 = 0;
        int mf0 = 0, mf1 = 0, mt_beat = 0;
        int ng = 0, gap_run = 0, len;
        logic after_last = 1'b0;
        logic done = 1'b0;
        logic fire0, fire1;
        logic [1:0] prev_grant = 2'b00;
        logic [15:0] got = '0;
        first_grant = -1;
        last_fire = -1;
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            S0Tvalid = (cyc >= d0) && (f0 < n0);
            S0Tdata  = {8'h00, 8'(f0), 16'(b0)};
            S0Tlast  = (b0 == len0 - 1);
            S1Tvalid = (f1 < n1);
            S1Tdata  = {8'h01, 8'(f1), 16'(b1)};
            S1Tlast  = (b1 == len1 - 1);
            MTready  = tog ? ~cyc[0] : 1'b1;
            #1;
            if (after_last) begin
                if (Busy && !MTvalid && Grant == 2'b00) begin
                    gap_run++;
                end else begin
                    chk("gap_len", gap_run, 32'(GapCycles));
                    after_last = 1'b0;
                end
            end
            if (Grant == 2'b00) begin
                chk("idle_mtvalid", 32'(MTvalid), 0);
                chk("idle_ready", {30'd0, S0Tready, S1Tready}, 0);
                chk("idle_mtdata", MTdata, 0);
            end else if (Grant == 2'b01) begin
                chk("s0_other_ready", 32'(S1Tready), 0);
                chk("s0_ready", 32'(S0Tready), 32'(MTready));
                chk("s0_valid", 32'(MTvalid), 32'(S0Tvalid));
                chk("s0_data", MTdata, S0Tdata);
                chk("s0_keep", 32'(MTkeep), 32'(S0Tkeep));
            end else if (Grant == 2'b10) begin
                chk("s1_other_ready", 32'(S0Tready), 0);
                chk("s1_ready", 32'(S1Tready), 32'(MTready));
                chk("s1_valid", 32'(MTvalid), 32'(S1Tvalid));
                chk("s1_data", MTdata, S1Tdata);
                chk("s1_keep", 32'(MTkeep), 32'(S1Tkeep));
            end else begin
                chk("grant_onehot", 32'(Grant), 32'h1);
            end
            if (Grant != 2'b00 && prev_grant == 2'b00) begin
                if (ng < 16) got[ng] = Grant[1];
                ng++;
                if (first_grant < 0) first_grant = cyc;
            end
            prev_grant = Grant;
            fire0 = S0Tvalid & S0Tready;
            fire1 = S1Tvalid & S1Tready;
            if (MTvalid && MTready) begin
                len = Grant[1] ? len1 : len0;
                chk("beat_seq", 32'(MTdata[15:0]), mt_beat);
                chk("frame_idx", 32'(MTdata[23:16]), Grant[1] ? mf1 : mf0);
                chk("beat_last", 32'(MTlast), 32'(mt_beat == len - 1));
                if (MTlast) begin
                    mt_beat = 0;
                    if (Grant[1]) mf1++; else mf0++;
                    after_last = 1'b1;
                    gap_run = 0;
                    last_fire = cyc;
                end else begin
                    mt_beat++;
                end
            end
            if (f0 == n0 && f1 == n1 && !after_last && !Busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (fire0) begin
                if (S0Tlast) begin f0++; b0 = 0; ef0++; end
                else b0++;
            end
            if (fire1) begin
                if (S1Tlast) begin f1++; b1 = 0; ef1++; end
                else b1++;
            end
        end
        S0Tvalid = 1'b0;
        S1Tvalid = 1'b0;
        chk("run_complete", 32'(done), 1);
        chk("grant_count", ng, n0 + n1);
        for (int i = 0; i < n0 + n1 && i < 16; i++) begin
            chk($sformatf("grant_order[%0d]", i), 32'(got[i]), 32'(order[i]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        S0Tdata = '0; S0Tkeep = 4'hF; S0Tvalid = 1'b0; S0Tlast = 1'b0;
        S1Tdata = '0; S1Tkeep = 4'h3; S1Tvalid = 1'b0; S1Tlast = 1'b0;
        MTready = 1'b1;
        GapCycles = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_grant", 32'(Grant), 0);
        chk("reset_busy", 32'(Busy), 0);
        chk("reset_mtvalid", 32'(MTvalid), 0);
        chk("reset_ready", {30'd0, S0Tready, S1Tready}, 0);
        rst_n = 1'b1;

        // Single S0 3-beat frame: grant one cycle later, beats back to back.
        run(1, 0, 3, 1, 0, 1'b0, 16'h0000, fg, lf);
        chk("sc1_latency", fg, 1);
        chk("sc1_last_beat", lf, 3);

        // Both sources always valid: four trace frames per control frame.
        run(8, 2, 2, 2, 0, 1'b0, 16'h0210, fg, lf);

        // Programmable gap between back-to-back trace frames.
        GapCycles = 8'd5;
        run(3, 0, 2, 1, 0, 1'b0, 16'h0000, fg, lf);
        GapCycles = 8'd0;

        // MTready toggling during a control frame while trace waits.
        run(1, 1, 2, 4, 1, 1'b1, 16'h0001, fg, lf);

        // Mid-frame asynchronous reset with both sources valid.
        @(posedge clk);
        #1;
        S0Tvalid = 1'b1; S0Tdata = 32'h0; S0Tlast = 1'b0;
        S1Tvalid = 1'b1; S1Tdata = 32'h0100_0000; S1Tlast = 1'b0;
        MTready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_pre_grant", 32'(Grant), 32'h1);
        @(posedge clk);
        #1;
        S0Tdata = 32'h1;
        #1;
        chk("rst_pre_mtvalid", 32'(MTvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mtvalid", 32'(MTvalid), 0);
        chk("rst_s0ready", 32'(S0Tready), 0);
        chk("rst_s1ready", 32'(S1Tready), 0);
        chk("rst_grant", 32'(Grant), 0);
        chk("rst_busy", 32'(Busy), 0);
        S0Tvalid = 1'b0;
        S1Tvalid = 1'b0;
        ef0 = 0;
        ef1 = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // RunCnt restarts at 0: four single-beat trace frames, then control.
        run(4, 1, 1, 1, 0, 1'b0, 16'h0010, fg, lf);
        run(3, 2, 2, 3, 0, 1'b0, 16'h0018, fg, lf);
`ifdef ETH_TX_ARB_STATS_EN
        chk("frames0", Frames0, 32'(ef0));
        chk("frames1", Frames1, 32'(ef1));
        chk("frames0_total", Frames0, 32'd7);
        chk("frames1_total", Frames1, 32'd3);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
